// File: rtl/counter_cmd_seq_pkg.sv
// rtl/counter_cmd_seq_pkg.sv - command types and mode constants for the counter command sequencer
package counter_cmd_seq_pkg;

  localparam int DATA_W = 4;
  localparam int REP_W  = 8;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_UP   = 2'b01;
  localparam logic [1:0] MODE_DOWN = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  typedef struct packed {
    logic [1:0]        modo;
    logic [DATA_W-1:0] d;
    logic [REP_W-1:0]  rep;
  } cmd_t;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } seq_state_t;

  // A load only needs one enabled cycle, so its repeat field is ignored.
  function automatic logic [REP_W-1:0] run_rem(input cmd_t c);
    return (c.modo == MODE_LOAD) ? '0 : c.rep;
  endfunction

endpackage

// File: rtl/counter_cmd_seq_fifo.sv
// rtl/counter_cmd_seq_fifo.sv - synchronous command FIFO with occupancy level
module counter_cmd_seq_fifo
  import counter_cmd_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  cmd_t                   wdata,
  input  logic                   pop,
  output cmd_t                   rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = DEPTH[AW:0];

  cmd_t          mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == FULL_LEVEL);
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) begin
        wptr <= wptr + 1'b1;
      end
      if (do_pop) begin
        rptr <= rptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        level <= level + 1'b1;
      end else if (do_pop && !do_push) begin
        level <= level - 1'b1;
      end
    end
  end

endmodule

// File: rtl/counter_cmd_seq.sv
// rtl/counter_cmd_seq.sv - replays queued {mode, data, repeat} commands as counter ENABLE runs
module counter_cmd_seq
  import counter_cmd_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   RESET,
  input  logic                   CMD_VALID,
  output logic                   CMD_READY,
  input  logic [1:0]             CMD_MODO,
  input  logic [DATA_W-1:0]      CMD_D,
  input  logic [REP_W-1:0]       CMD_REP,
  input  logic                   HOLD,
  output logic                   ENABLE,
  output logic [1:0]             MODO,
  output logic [DATA_W-1:0]      D,
  output logic                   BUSY,
  output logic                   DONE,
  output logic [$clog2(DEPTH):0] LEVEL
);

  seq_state_t       state;
  seq_state_t       state_n;
  cmd_t             wcmd;
  cmd_t             head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             finishing;
  logic [REP_W-1:0] rem;
  logic [REP_W-1:0] rem_n;
  logic             enable_n;
  logic             done_n;

  assign CMD_READY = !fifo_full && !RESET;
  assign push      = CMD_VALID && CMD_READY;
  assign wcmd      = '{modo: CMD_MODO, d: CMD_D, rep: CMD_REP};
  assign BUSY      = (state == ST_RUN);
  // The counter consumed its final cycle of the current command this clock.
  assign finishing = ENABLE && (rem == '0);

  counter_cmd_seq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (RESET),
    .push  (push),
    .wdata (wcmd),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (LEVEL)
  );

  always_ff @(posedge clk) begin
    if (RESET) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_n = ST_RUN;
        end
      end
      ST_RUN: begin
        if (finishing) begin
          if (!fifo_empty) begin
            pop = 1'b1;
          end else begin
            state_n = ST_IDLE;
          end
        end
      end
    endcase
  end

  // Paused cycles (ENABLE low) make no progress; HOLD only gates the next ENABLE.
  always_comb begin
    enable_n = 1'b0;
    rem_n    = rem;
    done_n   = 1'b0;
    if (pop) begin
      enable_n = !HOLD;
      rem_n    = run_rem(head);
    end
    if (state == ST_RUN) begin
      if (!ENABLE) begin
        enable_n = !HOLD;
      end else if (rem != '0) begin
        rem_n    = rem - 1'b1;
        enable_n = !HOLD;
      end else begin
        done_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      ENABLE <= 1'b0;
      MODO   <= '0;
      D      <= '0;
      rem    <= '0;
      DONE   <= 1'b0;
    end else begin
      ENABLE <= enable_n;
      rem    <= rem_n;
      DONE   <= done_n;
      if (pop) begin
        MODO <= head.modo;
        D    <= head.d;
      end
    end
  end

endmodule
